// File: rtl/serial_adder.sv
// Bit-serial adder: two half-adder cells and a carry flop add two
// WIDTH-bit operands LSB first, one bit per clock, with valid/ready on both sides.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] SUM,
   output logic             CARRY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             carry_q, carry_d;
   logic             ov_q, ov_d;

   logic             p, g, s, h;
   logic [WIDTH-1:0] s_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         carry_q <= carry_d;
         ov_q    <= ov_d;
      end
   end

   // The new sum bit enters at the MSB; written this way so WIDTH=1 works.
   always_comb begin
      p       = a_q[0] ^ b_q[0];
      g       = a_q[0] & b_q[0];
      s       = p ^ c_q;
      h       = p & c_q;
      s_shift = s_q >> 1;
      s_shift[WIDTH-1] = s;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      carry_d = carry_q;
      ov_d    = ov_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = A_in;
               b_d     = B_in;
               c_d     = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            c_d   = g | h;
            s_d   = s_shift;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               sum_d   = s_shift;
               carry_d = g | h;
               ov_d    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == SHIFT) || (state_q == DONE);
   assign out_valid = ov_q;
   assign SUM       = sum_q;
   assign CARRY     = carry_q;

endmodule
